// File: rtl/wb_cmd_master_if.sv
// wb_cmd_master_if: command stream, response stream and Wishbone master bus signals
// for wb_cmd_master.
//   master modport : the wb_cmd_master side. It receives commands and acks and drives
//                    responses and the Wishbone strobes.
//   slave  modport : the environment side. This is the command producer, the response
//                    consumer and the Wishbone slave.
interface wb_cmd_master_if;
   // command stream
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [31:0] cmd_adr;
   logic [31:0] cmd_dat;
   logic [3:0]  cmd_sel;
   // response stream
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   // wishbone master port
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic        wbm_ack_i;
   logic [31:0] wbm_dat_i;
   // status
   logic        busy;

   modport master (
      input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_ack_i, wbm_dat_i,
      output cmd_ready, rsp_valid, rsp_dat, rsp_err,
             wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, busy
   );

   modport slave (
      output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_ack_i, wbm_dat_i,
      input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
             wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, busy
   );
endinterface

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone B4 classic single-beat master. It takes one command from a
// valid/ready stream and runs one read or write cycle with a wait-state timeout. It then
// returns the data and the error status on a valid/ready response stream. Only one
// transaction is outstanding at a time.
//   wb_clk_i  : clock, rising edge
//   wb_rst_i  : asynchronous active-high reset
//   bus       : wb_cmd_master_if.master. It carries the cmd_* stream, the rsp_* stream,
//               the wbm_* bus and busy.
// Every output is a register or a decode of the state register. wbm_ack_i and
// wbm_dat_i do not reach any output combinationally.
module wb_cmd_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   wb_cmd_master_if.master bus
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state;
   logic             cyc;
   logic             we_q;
   logic [3:0]       sel_q;
   logic [31:0]      adr_q;
   logic [31:0]      dat_q;
   logic [CNT_W-1:0] cnt;
   logic             rsp_valid_q;
   logic [31:0]      rsp_dat_q;
   logic             rsp_err_q;

   // Transaction sequencer. The ack is looked at only in BUS, so a stray ack is dropped.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state       <= IDLE;
         cyc         <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         adr_q       <= '0;
         dat_q       <= '0;
         cnt         <= '0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  we_q  <= bus.cmd_we;
                  adr_q <= bus.cmd_adr;
                  dat_q <= bus.cmd_dat;
                  sel_q <= bus.cmd_sel;
                  cyc   <= 1'b1;
                  cnt   <= '0;
                  state <= BUS;
               end
            end
            BUS: begin
               // An ack in the last allowed cycle takes priority over the timeout.
               if (bus.wbm_ack_i) begin
                  cyc         <= 1'b0;
                  rsp_dat_q   <= we_q ? 32'h0 : bus.wbm_dat_i;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state       <= RESP;
               end else if (cnt == CNT_LAST) begin
                  cyc         <= 1'b0;
                  rsp_dat_q   <= 32'h0;
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  state       <= RESP;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output drive. The wbm_* fields keep their last values after the cycle ends.
   assign bus.cmd_ready = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.wbm_cyc_o = cyc;
   assign bus.wbm_stb_o = cyc;
   assign bus.wbm_we_o  = we_q;
   assign bus.wbm_sel_o = sel_q;
   assign bus.wbm_adr_o = adr_q;
   assign bus.wbm_dat_o = dat_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_dat   = rsp_dat_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: self-checking bench for wb_cmd_master. The main instance uses
// TIMEOUT_CYCLES=8. A second instance uses TIMEOUT_CYCLES=1 to cover the single-cycle
// timeout case.
module tb_wb_cmd_master;
   localparam int unsigned T = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_cmd_master_if bus ();
   wb_cmd_master_if bus1 ();

   wb_cmd_master #(.TIMEOUT_CYCLES(T)) u_dut  (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus));
   wb_cmd_master #(.TIMEOUT_CYCLES(1)) u_dut1 (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus1));

   int n_chk  = 0;
   int n_pass = 0;

   // Expected outcome of one transaction.
   // ack_at is the stb cycle (1-based) that carries the ack. A value of 0 means no ack.
   function automatic void model(input bit we, input logic [31:0] rdat, input int ack_at,
                                 input int tmo, output int stb_n, output logic [31:0] d,
                                 output bit err);
      if (ack_at >= 1 && ack_at <= tmo) begin
         stb_n = ack_at; err = 1'b0; d = we ? 32'h0 : rdat;
      end else begin
         stb_n = tmo;    err = 1'b1; d = 32'h0;
      end
   endfunction

   task automatic init_inputs();
      bus.cmd_valid  = 0; bus.cmd_we  = 0; bus.cmd_adr  = 0; bus.cmd_dat  = 0; bus.cmd_sel  = 0;
      bus.rsp_ready  = 0; bus.wbm_ack_i  = 0; bus.wbm_dat_i  = 0;
      bus1.cmd_valid = 0; bus1.cmd_we = 0; bus1.cmd_adr = 0; bus1.cmd_dat = 0; bus1.cmd_sel = 0;
      bus1.rsp_ready = 0; bus1.wbm_ack_i = 0; bus1.wbm_dat_i = 0;
   endtask

   // Runs one transaction on the main instance and checks it against the model.
   // The response is held off for rsp_wait cycles. When noise is set, that window also
   // carries a spurious ack and new cmd_* values.
   task automatic do_txn(input string nm, input bit we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input int ack_at,
                         input logic [31:0] rdat, input int rsp_wait, input bit noise);
      int          exp_stb, stb_n, lat;
      logic [31:0] exp_d;
      bit          exp_e, done;
      model(we, rdat, ack_at, T, exp_stb, exp_d, exp_e);
      @(negedge clk);
      bus.cmd_valid = 1; bus.cmd_we = we; bus.cmd_adr = adr; bus.cmd_dat = dat; bus.cmd_sel = sel;
      n_chk++; if (bus.cmd_ready !== 1'b1) $display("FAIL %s cmd_ready got %b exp 1", nm, bus.cmd_ready); else n_pass++;
      @(posedge clk); #1;
      bus.cmd_valid = 0; bus.cmd_we = ~we; bus.cmd_adr = $urandom; bus.cmd_dat = $urandom; bus.cmd_sel = 4'($urandom);
      stb_n = 0; lat = 0; done = 0;
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge clk); lat++;
         if (bus.wbm_stb_o === 1'b1) begin
            stb_n++;
            n_chk++;
            if ({bus.wbm_cyc_o, bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_sel_o} !== {1'b1, we, adr, dat, sel})
               $display("FAIL %s bus_fields got cyc=%b we=%b adr=%h dat=%h sel=%h exp cyc=1 we=%b adr=%h dat=%h sel=%h",
                        nm, bus.wbm_cyc_o, bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_sel_o, we, adr, dat, sel);
            else n_pass++;
            bus.wbm_ack_i = (stb_n == ack_at);
            bus.wbm_dat_i = (stb_n == ack_at) ? rdat : $urandom;
         end else begin
            bus.wbm_ack_i = 0; done = 1;
         end
      end
      n_chk++; if (!done) begin $display("FAIL %s stb_end got stuck exp drop within budget", nm); return; end else n_pass++;
      n_chk++; if (stb_n !== exp_stb) $display("FAIL %s stb_cycles got %0d exp %0d", nm, stb_n, exp_stb); else n_pass++;
      n_chk++; if (bus.rsp_valid !== 1'b1) $display("FAIL %s rsp_valid got %b exp 1", nm, bus.rsp_valid); else n_pass++;
      n_chk++; if (bus.rsp_dat !== exp_d) $display("FAIL %s rsp_dat got %h exp %h", nm, bus.rsp_dat, exp_d); else n_pass++;
      n_chk++; if (bus.rsp_err !== exp_e) $display("FAIL %s rsp_err got %b exp %b", nm, bus.rsp_err, exp_e); else n_pass++;
      for (int w = 0; w < rsp_wait; w++) begin
         if (noise) begin
            bus.wbm_ack_i = 1; bus.wbm_dat_i = $urandom;
            bus.cmd_valid = 1; bus.cmd_we = 1'($urandom); bus.cmd_adr = $urandom; bus.cmd_dat = $urandom;
         end
         @(negedge clk); lat++;
         n_chk++;
         if ({bus.rsp_valid, bus.rsp_dat, bus.rsp_err, bus.cmd_ready, bus.wbm_cyc_o, bus.wbm_adr_o} !==
             {1'b1, exp_d, exp_e, 1'b0, 1'b0, adr})
            $display("FAIL %s hold got v=%b d=%h e=%b rdy=%b cyc=%b adr=%h exp v=1 d=%h e=%b rdy=0 cyc=0 adr=%h",
                     nm, bus.rsp_valid, bus.rsp_dat, bus.rsp_err, bus.cmd_ready, bus.wbm_cyc_o, bus.wbm_adr_o,
                     exp_d, exp_e, adr);
         else n_pass++;
      end
      bus.rsp_ready = 1; bus.cmd_valid = 0; bus.wbm_ack_i = 0;
      @(negedge clk); lat++;
      bus.rsp_ready = 0;
      n_chk++; if ({bus.rsp_valid, bus.cmd_ready, bus.busy} !== 3'b010)
         $display("FAIL %s after_take got v=%b rdy=%b busy=%b exp v=0 rdy=1 busy=0", nm, bus.rsp_valid, bus.cmd_ready, bus.busy);
      else n_pass++;
      n_chk++; if (lat !== exp_stb + 2 + rsp_wait) $display("FAIL %s latency got %0d exp %0d", nm, lat, exp_stb + 2 + rsp_wait); else n_pass++;
      n_chk++; if ({bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_sel_o} !== {we, adr, dat, sel})
         $display("FAIL %s retain got adr=%h dat=%h exp adr=%h dat=%h", nm, bus.wbm_adr_o, bus.wbm_dat_o, adr, dat);
      else n_pass++;
   endtask

   task automatic test_reset();
      init_inputs();
      #2;
      n_chk++;
      if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_dat, bus.rsp_err, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o,
           bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_dat_o, bus.busy} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0})
         $display("FAIL reset_values got rdy=%b v=%b d=%h e=%b cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h busy=%b exp rdy=1 others 0",
                  bus.cmd_ready, bus.rsp_valid, bus.rsp_dat, bus.rsp_err, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o,
                  bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_dat_o, bus.busy);
      else n_pass++;
      @(negedge clk); @(negedge clk);
      rst = 0;
   endtask

   task automatic test_zero_wait_write();
      do_txn("zero_wait_write", 1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1, $urandom, 0, 1'b0);
   endtask

   task automatic test_read_wait3();
      do_txn("read_wait3", 1'b0, 32'h3000_0010, $urandom, 4'h3, 4, 32'h1234_5678, 0, 1'b0);
   endtask

   task automatic test_timeout();
      do_txn("timeout", 1'b0, 32'h3000_0020, $urandom, 4'hF, 0, $urandom, 0, 1'b0);
      do_txn("after_timeout", 1'b0, 32'h3000_0024, $urandom, 4'hC, 2, 32'h0F0F_1234, 1, 1'b0);
   endtask

   task automatic test_ack_at_timeout();
      do_txn("ack_at_timeout", 1'b0, 32'h3000_0030, $urandom, 4'hF, T, 32'hA5A5_A5A5, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      do_txn("backpressure", 1'b0, 32'h3000_0040, 32'h1111_2222, 4'h5, 2, 32'hCAFE_0001, 5, 1'b1);
   endtask

   task automatic test_reset_mid();
      int stb_n;
      @(negedge clk);
      bus.cmd_valid = 1; bus.cmd_we = 0; bus.cmd_adr = 32'h3000_0050; bus.cmd_sel = 4'hF;
      @(posedge clk); #1 bus.cmd_valid = 0;
      stb_n = 0;
      for (int c = 0; c < 20 && stb_n < 3; c++) begin
         @(negedge clk);
         if (bus.wbm_stb_o === 1'b1) stb_n++;
      end
      rst = 1;
      #1;
      n_chk++; if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid, bus.cmd_ready, bus.busy} !== 5'b00010)
         $display("FAIL reset_mid_async got cyc=%b stb=%b v=%b rdy=%b busy=%b exp 0 0 0 1 0 (stb_seen=%0d)",
                  bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid, bus.cmd_ready, bus.busy, stb_n);
      else n_pass++;
      @(negedge clk); @(negedge clk);
      rst = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_chk++; if ({bus.rsp_valid, bus.wbm_cyc_o, bus.cmd_ready} !== 3'b001)
            $display("FAIL reset_mid_idle got v=%b cyc=%b rdy=%b exp v=0 cyc=0 rdy=1", bus.rsp_valid, bus.wbm_cyc_o, bus.cmd_ready);
         else n_pass++;
      end
      do_txn("after_reset", 1'b0, 32'h3000_0054, $urandom, 4'hF, 3, 32'h7777_8888, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++)
         do_txn($sformatf("random_%0d", i), 1'($urandom), $urandom, $urandom, 4'($urandom),
                int'($urandom_range(0, 10)), $urandom, int'($urandom_range(0, 3)), 1'($urandom));
   endtask

   task automatic test_timeout_one();
      @(negedge clk);
      bus1.cmd_valid = 1; bus1.cmd_we = 0; bus1.cmd_adr = 32'h3000_0100; bus1.cmd_sel = 4'hF;
      @(posedge clk); #1 bus1.cmd_valid = 0;
      @(negedge clk);
      n_chk++; if (bus1.wbm_stb_o !== 1'b1) $display("FAIL t1_err stb got %b exp 1", bus1.wbm_stb_o); else n_pass++;
      @(negedge clk);
      n_chk++; if ({bus1.wbm_stb_o, bus1.rsp_valid, bus1.rsp_err, bus1.rsp_dat} !== {1'b0, 1'b1, 1'b1, 32'h0})
         $display("FAIL t1_err rsp got stb=%b v=%b e=%b d=%h exp stb=0 v=1 e=1 d=0", bus1.wbm_stb_o, bus1.rsp_valid, bus1.rsp_err, bus1.rsp_dat);
      else n_pass++;
      bus1.rsp_ready = 1;
      @(negedge clk);
      bus1.rsp_ready = 0;
      n_chk++; if ({bus1.rsp_valid, bus1.cmd_ready} !== 2'b01)
         $display("FAIL t1_err take got v=%b rdy=%b exp v=0 rdy=1", bus1.rsp_valid, bus1.cmd_ready);
      else n_pass++;
      bus1.cmd_valid = 1; bus1.cmd_adr = 32'h3000_0104;
      @(posedge clk); #1 bus1.cmd_valid = 0;
      @(negedge clk);
      n_chk++; if (bus1.wbm_stb_o !== 1'b1) $display("FAIL t1_ack stb got %b exp 1", bus1.wbm_stb_o); else n_pass++;
      bus1.wbm_ack_i = 1; bus1.wbm_dat_i = 32'h0BAD_F00D;
      @(negedge clk);
      bus1.wbm_ack_i = 0;
      n_chk++; if ({bus1.wbm_stb_o, bus1.rsp_valid, bus1.rsp_err, bus1.rsp_dat} !== {1'b0, 1'b1, 1'b0, 32'h0BAD_F00D})
         $display("FAIL t1_ack rsp got stb=%b v=%b e=%b d=%h exp stb=0 v=1 e=0 d=0badf00d", bus1.wbm_stb_o, bus1.rsp_valid, bus1.rsp_err, bus1.rsp_dat);
      else n_pass++;
      bus1.rsp_ready = 1;
      @(negedge clk);
      bus1.rsp_ready = 0;
   endtask

   initial begin
      test_reset();
      test_zero_wait_write();
      test_read_wait3();
      test_timeout();
      test_ack_at_timeout();
      test_backpressure();
      test_reset_mid();
      test_random();
      test_timeout_one();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no finish exp finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
